// File: rtl/ir_disp_pkg.sv
// Shared types and seven-segment glyphs for the IR frame display controller.
// Segments are active-low, bit0 = a .. bit6 = g.
package ir_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    ERR
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b000_0110;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    return SEG_HEX[n];
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every DIV clocks.
// clr restarts the count so the first tick lands a full period later.
module disp_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ir_disp_ctrl.sv
// NEC frame display controller: shows addr / repeat count / cmd on six digits.
// Define IR_DISP_BLINK_EN to blink the repeat count (SHOW) and the E (ERR).
module ir_disp_ctrl
  import ir_disp_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_valid,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_cmd,
  output logic       o_frame_ready,
  input  logic       i_repeat,
  input  logic       i_err,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic [6:0] o_hex4,
  output logic [6:0] o_hex5,
  output logic       o_busy
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int HW  = $clog2(HOLD_MS + 1);

  state_t state, state_n;

  logic xfer, ld_go, err_go, rep_go, exp_go;
  logic hold_load, tick, blink_off;
  logic [7:0] addr_q, cmd_q, rpt_q;
  logic [HW-1:0] hold_q;
  logic [5:0][6:0] hex_n, hex_q;

  // Qualified events, made mutually exclusive in priority order.
  assign xfer   = i_frame_valid & o_frame_ready;
  assign ld_go  = (state == LOAD);
  assign err_go = ~xfer & i_err
                & ((state == IDLE) | (state == SHOW));
  assign rep_go = ~xfer & ~err_go & i_repeat
                & (state == SHOW);
  assign exp_go = ~xfer & ~err_go & ~rep_go & tick
                & (hold_q == HW'(1))
                & ((state == SHOW) | (state == ERR));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      xfer:    state_n = LOAD;
      ld_go:   state_n = SHOW;
      err_go:  state_n = ERR;
      exp_go:  state_n = IDLE;
      default: state_n = state;
    endcase
  end

  always_comb begin
    o_frame_ready = (state != LOAD);
    o_busy        = (state != IDLE);
    hold_load     = ld_go | err_go | rep_go;
  end

  disp_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (hold_load),
    .tick (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= '0;
    end else if (hold_load) begin
      hold_q <= HW'(HOLD_MS);
    end else if (tick && hold_q != '0) begin
      hold_q <= hold_q - HW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q <= '0;
      cmd_q  <= '0;
    end else if (xfer) begin
      addr_q <= i_addr;
      cmd_q  <= i_cmd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rpt_q <= '0;
    end else if (ld_go) begin
      rpt_q <= '0;
    end else if (rep_go && rpt_q != 8'hFF) begin
      rpt_q <= rpt_q + 8'd1;
    end
  end

`ifdef IR_DISP_BLINK_EN
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  logic [BW-1:0] blink_cnt;

  // Phase follows the tick generator, which restarts on every hold load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (hold_load) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  logic blink_unused;
  assign blink_unused = ^BLINK_MS;
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    hex_n = {6{SEG_BLANK}};
    unique case (state)
      SHOW: begin
        hex_n[5] = seg_of(addr_q[7:4]);
        hex_n[4] = seg_of(addr_q[3:0]);
        hex_n[3] = blink_off ? SEG_BLANK
                             : seg_of(rpt_q[7:4]);
        hex_n[2] = blink_off ? SEG_BLANK
                             : seg_of(rpt_q[3:0]);
        hex_n[1] = seg_of(cmd_q[7:4]);
        hex_n[0] = seg_of(cmd_q[3:0]);
      end
      ERR: begin
        hex_n[5] = blink_off ? SEG_BLANK : SEG_E;
      end
      default: begin
        hex_n = {6{SEG_BLANK}};
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hex_q <= {6{SEG_BLANK}};
    end else begin
      hex_q <= hex_n;
    end
  end

  assign o_hex0 = hex_q[0];
  assign o_hex1 = hex_q[1];
  assign o_hex2 = hex_q[2];
  assign o_hex3 = hex_q[3];
  assign o_hex4 = hex_q[4];
  assign o_hex5 = hex_q[5];

endmodule

// File: tb/tb_ir_disp_ctrl.sv
// Bench for ir_disp_ctrl: cycle-count reference model plus directed pins.
// Honours IR_DISP_BLINK_EN when the design is built with it.
module tb_ir_disp_ctrl;

  localparam int CLK_HZ   = 4000;
  localparam int HOLD_MS  = 3;
  localparam int BLINK_MS = 1;
  localparam int CYC      = CLK_HZ / 1000;
  localparam int HOLD_CYC = HOLD_MS * CYC;
  localparam int BLNK_CYC = BLINK_MS * CYC;

`ifdef IR_DISP_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_SHOW = 2;
  localparam int M_ERR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fv  = 1'b0;
  logic       rep = 1'b0;
  logic       err = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] cmd  = 8'h00;
  logic       o_frame_ready, o_busy;
  logic [6:0] o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ir_disp_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .HOLD_MS  (HOLD_MS),
    .BLINK_MS (BLINK_MS)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_valid (fv),
    .i_addr        (addr),
    .i_cmd         (cmd),
    .o_frame_ready (o_frame_ready),
    .i_repeat      (rep),
    .i_err         (err),
    .o_hex0        (o_hex0),
    .o_hex1        (o_hex1),
    .o_hex2        (o_hex2),
    .o_hex3        (o_hex3),
    .o_hex4        (o_hex4),
    .o_hex5        (o_hex5),
    .o_busy        (o_busy)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, want, $time);
    end
  endtask

  // Glyphs built from the lit segment letters, then inverted (active-low).
  string segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg",
    "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg",
    "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] r;
    string s;
    r = 7'h7F;
    s = segs[n];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  // Reference model: mode plus cycles elapsed since the last hold load.
  int         m_mode  = M_IDLE;
  logic [7:0] m_addr  = 8'h00;
  logic [7:0] m_cmd   = 8'h00;
  int         m_rpt   = 0;
  int         m_since = 0;

  function automatic logic [41:0] disp();
    logic off;
    logic [7:0] r;
    off = BLINK_EN && (((m_since / BLNK_CYC) % 2) == 1);
    r = 8'(m_rpt);
    if (m_mode == M_SHOW)
      return {glyph(m_addr[7:4]), glyph(m_addr[3:0]),
              off ? 7'h7F : glyph(r[7:4]),
              off ? 7'h7F : glyph(r[3:0]),
              glyph(m_cmd[7:4]), glyph(m_cmd[3:0])};
    if (m_mode == M_ERR)
      return {off ? 7'h7F : 7'h06, {5{7'h7F}}};
    return {6{7'h7F}};
  endfunction

  task automatic model_step(input logic v, input logic [7:0] a,
                            input logic [7:0] c, input logic p,
                            input logic e);
    if (v && m_mode != M_LOAD) begin
      m_mode = M_LOAD;
      m_addr = a;
      m_cmd  = c;
    end else if (m_mode == M_LOAD) begin
      m_mode  = M_SHOW;
      m_rpt   = 0;
      m_since = 0;
    end else if (e && (m_mode == M_IDLE || m_mode == M_SHOW)) begin
      m_mode  = M_ERR;
      m_since = 0;
    end else if (p && m_mode == M_SHOW) begin
      m_rpt   = (m_rpt < 255) ? m_rpt + 1 : 255;
      m_since = 0;
    end else if ((m_mode == M_SHOW || m_mode == M_ERR)
                 && m_since + 1 == HOLD_CYC) begin
      m_mode = M_IDLE;
    end else begin
      m_since++;
    end
  endtask

  logic [41:0] e_hex;

  always @(posedge clk) begin
    if (rst) begin
      e_hex   = {6{7'h7F}};
      m_mode  = M_IDLE;
      m_addr  = 8'h00;
      m_cmd   = 8'h00;
      m_rpt   = 0;
      m_since = 0;
    end else begin
      e_hex = disp();
      model_step(fv, addr, cmd, rep, err);
    end
    #1;
    chk("hex", {o_hex5, o_hex4, o_hex3, o_hex2, o_hex1, o_hex0}, e_hex);
    chk("ready", o_frame_ready, m_mode != M_LOAD);
    chk("busy", o_busy, m_mode != M_IDLE);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] c);
    addr = a;
    cmd  = c;
    fv   = 1'b1;
    @(negedge clk);
    fv   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc(3);
    chk("rst_hex0", o_hex0, 7'h7F);
    chk("rst_hex5", o_hex5, 7'h7F);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_frame_ready, 1'b1);
    rst = 1'b0;
    cyc(2);

    // Frame 1A/C5: one LOAD cycle, then 1 A 0 0 C 5, idle after hold.
    send(8'h1A, 8'hC5);
    chk("load_ready", o_frame_ready, 1'b0);
    chk("load_busy", o_busy, 1'b1);
    cyc(1);
    chk("show_ready", o_frame_ready, 1'b1);
    chk("load_blank", o_hex5, 7'h7F);
    cyc(1);
    chk("d_hex5", o_hex5, 7'h79);
    chk("d_hex4", o_hex4, 7'h08);
    chk("d_hex3", o_hex3, 7'h40);
    chk("d_hex2", o_hex2, 7'h40);
    chk("d_hex1", o_hex1, 7'h46);
    chk("d_hex0", o_hex0, 7'h12);
    cyc(4);
    chk("blink_hex2", o_hex2, BLINK_EN ? 7'h7F : 7'h40);
    chk("blink_hex0", o_hex0, 7'h12);
    cyc(4);
    chk("blink_back", o_hex2, 7'h40);
    cyc(2);
    chk("hold_busy", o_busy, 1'b1);
    cyc(1);
    chk("exp_busy", o_busy, 1'b0);
    cyc(1);
    chk("exp_blank", o_hex5, 7'h7F);
    cyc(2);

    // Saturating repeat count.
    send(8'h3C, 8'h99);
    cyc(2);
    for (int i = 0; i < 300; i++) begin
      rep = 1'b1;
      @(negedge clk);
      rep = 1'b0;
      if (i < 299) cyc(7);
    end
    cyc(1);
    chk("sat_hex3", o_hex3, 7'h0E);
    chk("sat_hex2", o_hex2, 7'h0E);
    cyc(10);
    chk("sat_hold", o_busy, 1'b1);
    cyc(1);
    chk("sat_exp", o_busy, 1'b0);
    cyc(3);

    // Frame wins over a simultaneous error.
    addr = 8'h5E;
    cmd  = 8'h3B;
    fv   = 1'b1;
    err  = 1'b1;
    @(negedge clk);
    fv   = 1'b0;
    err  = 1'b0;
    chk("pri_ready", o_frame_ready, 1'b0);
    cyc(2);
    chk("pri_hex5", o_hex5, 7'h12);
    chk("pri_hex0", o_hex0, 7'h03);

    // Error from SHOW, repeat ignored.
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    rep = 1'b1;
    @(negedge clk);
    rep = 1'b0;
    chk("err_hex5", o_hex5, 7'h06);
    chk("err_hex4", o_hex4, 7'h7F);
    chk("err_hex0", o_hex0, 7'h7F);
    cyc(10);
    chk("err_hold", o_busy, 1'b1);
    cyc(1);
    chk("err_exp", o_busy, 1'b0);
    cyc(2);

    // Asynchronous reset mid-SHOW.
    send(8'h77, 8'h88);
    cyc(3);
    rst = 1'b1;
    #1;
    chk("arst_hex0", o_hex0, 7'h7F);
    chk("arst_hex5", o_hex5, 7'h7F);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_ready", o_frame_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_hex1", o_hex1, 7'h7F);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      addr = 8'($urandom);
      cmd  = 8'($urandom);
      fv   = ($urandom_range(15) == 0);
      err  = ($urandom_range(31) == 0);
      rep  = ($urandom_range(5) == 0);
      if ($urandom_range(499) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    fv  = 1'b0;
    err = 1'b0;
    rep = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
